store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Registered store queue directly downstream of the store byte-mask generator in the RISC-V core. It accepts store requests (address, data and 4-bit byte mask) from the execute/memory stage and holds them in a small in-order FIFO. It drains them to the data-memory write port over a request/grant handshake, and flags loads whose word address matches a pending store. Requests with an all-zero mask (non-stores) are accepted and discarded; they never reach memory.

## Interface
- DEPTH, 4: number of buffer entries; power of two, ≥2.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request present this cycle.
- st_ready  out  1  buffer can accept; equals !full.
- st_addr  in  32  byte address of the store.
- st_data  in  32  store data, already lane-aligned.
- st_mask  in  4  byte-enable from the mask generator; 4'b0000 means no write.
- mem_req  out  1  head entry valid, write requested.
- mem_gnt  in  1  memory accepts the head entry this cycle.
- mem_addr  out  32  head word address, {addr[31:2],2'b00}.
- mem_wdata  out  32  head data.
- mem_be  out  4  head byte mask.
- ld_addr  in  32  address of the load in the memory stage.
- ld_hazard  out  1  a valid entry, or the store being accepted this cycle, has word address == ld_addr[31:2].
- count  out  $clog2(DEPTH)+1  number of valid entries.
- empty  out  1  count == 0.

## Operation
- Circular FIFO: wr_ptr, rd_ptr, count. Push = st_valid && st_ready && (st_mask != 0). Pop = mem_req && mem_gnt.
- A handshake with st_mask == 0 completes (st_ready high) but does not push. Pointers and count are unchanged.
- Stored fields per entry: addr[31:2], data[31:0], mask[3:0]. Address bits [1:0] are dropped at push.
- mem_req = !empty. mem_addr, mem_wdata and mem_be are driven from the head entry. They hold stable while mem_req=1 and mem_gnt=0.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Full: st_ready=0, even when a pop occurs in the same cycle (no same-cycle pass-through). st_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH and never over- or underflows.
- ld_hazard is combinational over all valid entries plus the incoming push. The pipeline stalls the load while ld_hazard=1.
- No store-to-load data forwarding.
- No coalescing: two stores to the same word occupy two entries and drain in order.

## Timing
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, st_ready=1, mem_req=0, ld_hazard=0 (absent an incoming push).
- mem_addr, mem_wdata and mem_be have no defined reset value; they are don't-care while mem_req=0.
- Reset mid-operation discards all pending entries. mem_req falls immediately with rst_n, without waiting for a clock edge.
- Push latency: a store pushed at edge N appears on mem_req/mem_* after edge N, so it can be granted in cycle N+1 at the earliest.
- Pop: on grant at edge N, the next entry is on mem_* after edge N. Back-to-back grants therefore drain one entry per cycle.
- count and empty update on the same edge as the push or pop. st_ready depends only on count, so it is registered-derived with no combinational path from mem_gnt.
- ld_hazard is combinational from ld_addr, st_valid, st_addr, st_mask and the entry state.

## Test plan
- After reset, push SW addr=0x0000_1006, data=0xDEAD_BEEF, mask=4'b1111 with mem_gnt=0 -> next cycle mem_req=1, mem_addr=0x0000_1004, mem_be=4'hF, count=1. Signals hold for 3 cycles, then drop after mem_gnt=1.
- Push 4 stores (0x10, 0x14, 0x18, 0x1C) with mem_gnt=0 -> count=4, st_ready=0. A fifth st_valid is not accepted. Grant once -> mem_addr=0x14 next cycle and st_ready=1 one cycle after the grant.
- With count=2, push and grant in the same cycle -> count stays 2. Output order matches push order across pointer wrap, checked over 10 entries.
- Push with st_mask=4'b0000 -> st_ready=1, count unchanged, mem_req stays 0.
- Pending entry at 0x200 with ld_addr=0x203 -> ld_hazard=1. With ld_addr=0x204 -> 0. Incoming push to 0x300 with ld_addr=0x300 and the buffer empty -> ld_hazard=1 in that same cycle.
- With 3 entries pending, assert rst_n=0 between edges -> mem_req=0, count=0, empty=1 immediately. After release, no stale entry reappears.

Source files
------------

// File: rtl/store_write_buffer.sv
// In-order store queue between the byte-mask generator and the data-memory write port.
// Zero-mask requests handshake but are dropped; pending stores flag word-address load hazards.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_mask,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [29:0] entry_addr_q [DEPTH];
    logic [29:0] entry_addr_d [DEPTH];
    logic [31:0] entry_data_q [DEPTH];
    logic [31:0] entry_data_d [DEPTH];
    logic [3:0]  entry_mask_q [DEPTH];
    logic [3:0]  entry_mask_d [DEPTH];

    logic push;
    logic pop;
    logic [PTR_W-1:0] hz_offset;
    logic unused_addr_bits;

    // Byte-offset bits never matter: entries and hazards compare word addresses.
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // st_ready looks only at the registered count, so a pop never opens a same-cycle slot.
    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign mem_req  = !empty;
    assign count    = count_q;

    assign push = st_valid && st_ready && (st_mask != 4'b0000);
    assign pop  = mem_req && mem_gnt;

    assign mem_addr  = {entry_addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata = entry_data_q[rd_ptr_q];
    assign mem_be    = entry_mask_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        entry_mask_d = entry_mask_q;
        if (push) begin
            entry_addr_d[wr_ptr_q] = st_addr[31:2];
            entry_data_d[wr_ptr_q] = st_data;
            entry_mask_d[wr_ptr_q] = st_mask;
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        hz_offset = '0;
        ld_hazard = push && (st_addr[31:2] == ld_addr[31:2]);
        for (int i = 0; i < DEPTH; i++) begin
            hz_offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, hz_offset} < count_q) && (entry_addr_q[i] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; it is qualified by count.
    always_ff @(posedge clk) begin
        entry_addr_q <= entry_addr_d;
        entry_data_q <= entry_data_d;
        entry_mask_q <= entry_mask_d;
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with hand-computed expectations.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    store_write_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_mask   (st_mask),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mask  = m;
        tick();
        st_valid = 1'b0;
        st_mask  = 4'h0;
    endtask

    task automatic grant_one();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mask  = 4'h0;
        mem_gnt  = 1'b0;
        ld_addr  = 32'hFFFF_FFF0;
        tick();
        tick();
        check("rst_count",    32'(count), 32'd0);
        check("rst_empty",    32'(empty), 32'd1);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_mem_req",  32'(mem_req), 32'd0);
        check("rst_hazard",   32'(ld_hazard), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single store, held under back-pressure, then granted
        push_one(32'h0000_1006, 32'hDEAD_BEEF, 4'hF);
        check("sw_mem_req", 32'(mem_req), 32'd1);
        check("sw_addr",    mem_addr, 32'h0000_1004);
        check("sw_wdata",   mem_wdata, 32'hDEAD_BEEF);
        check("sw_be",      32'(mem_be), 32'hF);
        check("sw_count",   32'(count), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("sw_hold_req",  32'(mem_req), 32'd1);
            check("sw_hold_addr", mem_addr, 32'h0000_1004);
        end
        grant_one();
        check("sw_drop_req",   32'(mem_req), 32'd0);
        check("sw_drop_empty", 32'(empty), 32'd1);

        // Fill to full, reject a fifth, then drain in order
        for (int k = 0; k < 4; k++) begin
            push_one(32'h10 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF);
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(st_ready), 32'd0);
        st_valid = 1'b1;
        st_addr  = 32'h20;
        st_data  = 32'h5555_5555;
        st_mask  = 4'hF;
        tick();
        st_valid = 1'b0;
        check("full_reject_count", 32'(count), 32'd4);
        mem_gnt = 1'b1;
        #1;
        check("full_pop_ready_same", 32'(st_ready), 32'd0);
        tick();
        mem_gnt = 1'b0;
        check("full_pop_addr",  mem_addr, 32'h14);
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_ready", 32'(st_ready), 32'd1);
        for (int k = 1; k < 4; k++) begin
            check("drain_addr", mem_addr, 32'h10 + 32'(4 * k));
            check("drain_data", mem_wdata, 32'hA000_0000 + 32'(k));
            grant_one();
        end
        check("drain_empty_req", 32'(mem_req), 32'd0);

        // Simultaneous push/pop at count=2, ten entries across pointer wrap
        push_one(32'h100, 32'hB000_0000, 4'h3);
        push_one(32'h104, 32'hB000_0001, 4'h3);
        for (int k = 2; k < 10; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'h100 + 32'(4 * k);
            st_data  = 32'hB000_0000 + 32'(k);
            st_mask  = 4'h3;
            mem_gnt  = 1'b1;
            #1;
            check("pp_head_addr", mem_addr, 32'h100 + 32'(4 * (k - 2)));
            check("pp_head_data", mem_wdata, 32'hB000_0000 + 32'(k - 2));
            tick();
            check("pp_count", 32'(count), 32'd2);
        end
        st_valid = 1'b0;
        st_mask  = 4'h0;
        mem_gnt  = 1'b0;
        for (int k = 8; k < 10; k++) begin
            check("pp_tail_addr", mem_addr, 32'h100 + 32'(4 * k));
            check("pp_tail_be",   32'(mem_be), 32'h3);
            grant_one();
        end
        check("pp_empty", 32'(empty), 32'd1);

        // Zero-mask request handshakes but is discarded
        st_valid = 1'b1;
        st_addr  = 32'h400;
        st_mask  = 4'h0;
        #1;
        check("zm_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        check("zm_count",   32'(count), 32'd0);
        check("zm_mem_req", 32'(mem_req), 32'd0);

        // Load hazard against pending entry and incoming push
        push_one(32'h200, 32'hC0DE_0001, 4'h1);
        ld_addr = 32'h203;
        #1;
        check("hz_match", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h204;
        #1;
        check("hz_nomatch", 32'(ld_hazard), 32'd0);
        grant_one();
        check("hz_drained", 32'(empty), 32'd1);
        ld_addr  = 32'h300;
        st_valid = 1'b1;
        st_addr  = 32'h300;
        st_data  = 32'h1234_5678;
        st_mask  = 4'hC;
        #1;
        check("hz_incoming", 32'(ld_hazard), 32'd1);
        st_mask = 4'h0;
        #1;
        check("hz_incoming_nomask", 32'(ld_hazard), 32'd0);
        st_valid = 1'b0;
        tick();

        // Asynchronous reset with three pending entries
        for (int k = 0; k < 3; k++) begin
            push_one(32'h600 + 32'(4 * k), 32'hD000_0000 + 32'(k), 4'hF);
        end
        check("ar_pre_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_mem_req", 32'(mem_req), 32'd0);
        check("ar_count",   32'(count), 32'd0);
        check("ar_empty",   32'(empty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_post_req", 32'(mem_req), 32'd0);
        push_one(32'h500, 32'hE000_0000, 4'hF);
        check("ar_new_addr",  mem_addr, 32'h500);
        check("ar_new_count", 32'(count), 32'd1);
        grant_one();
        check("ar_no_stale", 32'(mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
